// File: rtl/wb_regfile_pkg.sv
// Shared register-file geometry and lane helpers for the writeback register file.
package wb_regfile_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int LANE_WIDTH = 16;
  localparam int LANE_COUNT = 4;
  localparam int VREG_WIDTH = LANE_WIDTH * LANE_COUNT;
  localparam int SREG_COUNT = 16;
  localparam int VREG_COUNT = 16;
  localparam int REG_IDX_W  = 4;
  localparam int LANE_IDX_W = 2;
  // Scoreboard slot index: MSB selects the vector bank, low bits the register.
  localparam int SB_IDX_W   = REG_IDX_W + 1;

  typedef logic [REG_WIDTH-1:0]  sregWord_t;
  typedef logic [VREG_WIDTH-1:0] vregWord_t;

  // Replace one 16-bit lane of a vector word, leaving the other lanes intact.
  function automatic vregWord_t mergeLane(input vregWord_t base,
                                          input logic [LANE_IDX_W-1:0] lane,
                                          input logic [LANE_WIDTH-1:0] data);
    vregWord_t merged;
    merged = base;
    merged[lane*LANE_WIDTH +: LANE_WIDTH] = data;
    return merged;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write counter bank: one counter per scalar and vector register,
// producing the decode hold signal for RAW hazards and counter saturation.
module wb_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                lock,
  input  logic                issueValid,
  input  logic [SB_IDX_W-1:0] issueSlot,
  input  logic                scalarWbActive,
  input  logic [REG_IDX_W-1:0] scalarWbIdx,
  input  logic                vectorWbActive,
  input  logic [REG_IDX_W-1:0] vectorWbIdx,
  input  logic [SB_IDX_W-1:0] srcSlot0,
  input  logic [SB_IDX_W-1:0] srcSlot1,
  input  logic [SB_IDX_W-1:0] srcSlotV,
  input  logic                srcUse0,
  input  logic                srcUse1,
  input  logic                srcUseV,
  output logic                depStall
);

  localparam int SLOTS = SREG_COUNT + VREG_COUNT;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pendCnt [SLOTS];
  logic [SLOTS-1:0]  wbHit;
  logic [SLOTS-1:0]  srcBlocked;
  logic [SLOTS-1:0]  destFull;
  logic              issueFire;

  // Per-slot writeback match; a last outstanding write landing now clears the hazard.
  always_comb begin
    wbHit = '0;
    if (scalarWbActive) wbHit[{1'b0, scalarWbIdx}] = 1'b1;
    if (vectorWbActive) wbHit[{1'b1, vectorWbIdx}] = 1'b1;
    for (int i = 0; i < SLOTS; i++) begin
      srcBlocked[i] = (pendCnt[i] != '0) && !((pendCnt[i] == CNT_ONE) && wbHit[i]);
      destFull[i]   = (pendCnt[i] == CNT_MAX) && !wbHit[i];
    end
  end

  // Hold decode on a busy used source or a saturated destination counter.
  always_comb begin
    depStall = 1'b0;
    if (lock) begin
      depStall = (srcUse0 && srcBlocked[srcSlot0]) ||
                 (srcUse1 && srcBlocked[srcSlot1]) ||
                 (srcUseV && srcBlocked[srcSlotV]) ||
                 (issueValid && destFull[issueSlot]);
    end
  end

  assign issueFire = lock && issueValid && !depStall;

  // Counter update: issue and matching writeback in one cycle cancel; no underflow.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < SLOTS; i++) pendCnt[i] <= '0;
    end else if (lock) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (issueFire && (issueSlot == SB_IDX_W'(i)) && !wbHit[i]) begin
          pendCnt[i] <= pendCnt[i] + CNT_ONE;
        end else if (wbHit[i] && !(issueFire && (issueSlot == SB_IDX_W'(i))) &&
                     (pendCnt[i] != '0)) begin
          pendCnt[i] <= pendCnt[i] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Scalar and vector register files with same-cycle write bypass and a
// pending-write scoreboard that stalls decode on unresolved dependencies.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                  I_CLOCK,
  input  logic                  I_RESET_N,
  input  logic                  I_LOCK,
  input  logic                  I_WriteBackEnable,
  input  logic [REG_IDX_W-1:0]  I_WriteBackRegIdx,
  input  logic [REG_WIDTH-1:0]  I_WriteBackData,
  input  logic                  I_WriteBackEnableV,
  input  logic [5:0]            I_WriteBackRegIdxV,
  input  logic [LANE_IDX_W-1:0] I_WriteBackRegIdxV_Idx,
  input  logic [VREG_WIDTH-1:0] I_WriteBackDataV,
  input  logic                  I_WriteBackLaneMode,
  input  logic                  I_IssueValid,
  input  logic [REG_IDX_W-1:0]  I_IssueDestIdx,
  input  logic                  I_IssueIsVector,
  input  logic [REG_IDX_W-1:0]  I_SrcIdx0,
  input  logic [REG_IDX_W-1:0]  I_SrcIdx1,
  input  logic [REG_IDX_W-1:0]  I_SrcIdxV,
  input  logic                  I_SrcUse0,
  input  logic                  I_SrcUse1,
  input  logic                  I_SrcUseV,
  output logic [REG_WIDTH-1:0]  O_SrcData0,
  output logic [REG_WIDTH-1:0]  O_SrcData1,
  output logic [VREG_WIDTH-1:0] O_SrcDataV,
  output logic                  O_DepStall
);

  sregWord_t sRegs [SREG_COUNT];
  vregWord_t vRegs [VREG_COUNT];

  logic                 sWrActive;
  logic                 vWrActive;
  logic [REG_IDX_W-1:0] vWrIdx;
  vregWord_t            vWrData;

  // Qualify both write ports; vector indices above 15 are not backed by storage.
  always_comb begin
    vWrIdx    = I_WriteBackRegIdxV[REG_IDX_W-1:0];
    sWrActive = I_LOCK && I_WriteBackEnable;
    vWrActive = I_LOCK && I_WriteBackEnableV && (I_WriteBackRegIdxV[5:4] == 2'b00);
    vWrData   = I_WriteBackLaneMode
              ? mergeLane(vRegs[vWrIdx], I_WriteBackRegIdxV_Idx, I_WriteBackData[LANE_WIDTH-1:0])
              : I_WriteBackDataV;
  end

  // Register-file storage; reset clears every register ahead of any write.
  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < SREG_COUNT; i++) sRegs[i] <= '0;
      for (int i = 0; i < VREG_COUNT; i++) vRegs[i] <= '0;
    end else begin
      if (sWrActive) sRegs[I_WriteBackRegIdx] <= I_WriteBackData;
      if (vWrActive) vRegs[vWrIdx] <= vWrData;
    end
  end

  // Combinational reads with bypass of the write landing this cycle.
  always_comb begin
    O_SrcData0 = (sWrActive && (I_WriteBackRegIdx == I_SrcIdx0)) ? I_WriteBackData : sRegs[I_SrcIdx0];
    O_SrcData1 = (sWrActive && (I_WriteBackRegIdx == I_SrcIdx1)) ? I_WriteBackData : sRegs[I_SrcIdx1];
    O_SrcDataV = (vWrActive && (vWrIdx == I_SrcIdxV)) ? vWrData : vRegs[I_SrcIdxV];
  end

  wb_scoreboard #(
    .PEND_W(PEND_W)
  ) uScoreboard (
    .clk           (I_CLOCK),
    .resetN        (I_RESET_N),
    .lock          (I_LOCK),
    .issueValid    (I_IssueValid),
    .issueSlot     ({I_IssueIsVector, I_IssueDestIdx}),
    .scalarWbActive(sWrActive),
    .scalarWbIdx   (I_WriteBackRegIdx),
    .vectorWbActive(vWrActive),
    .vectorWbIdx   (vWrIdx),
    .srcSlot0      ({1'b0, I_SrcIdx0}),
    .srcSlot1      ({1'b0, I_SrcIdx1}),
    .srcSlotV      ({1'b1, I_SrcIdxV}),
    .srcUse0       (I_SrcUse0),
    .srcUse1       (I_SrcUse1),
    .srcUseV       (I_SrcUseV),
    .depStall      (O_DepStall)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus a randomised read/write phase
// against a small storage model, checked through an expectation queue.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic                  I_CLOCK = 1'b0;
  logic                  I_RESET_N;
  logic                  I_LOCK;
  logic                  I_WriteBackEnable;
  logic [REG_IDX_W-1:0]  I_WriteBackRegIdx;
  logic [REG_WIDTH-1:0]  I_WriteBackData;
  logic                  I_WriteBackEnableV;
  logic [5:0]            I_WriteBackRegIdxV;
  logic [LANE_IDX_W-1:0] I_WriteBackRegIdxV_Idx;
  logic [VREG_WIDTH-1:0] I_WriteBackDataV;
  logic                  I_WriteBackLaneMode;
  logic                  I_IssueValid;
  logic [REG_IDX_W-1:0]  I_IssueDestIdx;
  logic                  I_IssueIsVector;
  logic [REG_IDX_W-1:0]  I_SrcIdx0, I_SrcIdx1, I_SrcIdxV;
  logic                  I_SrcUse0, I_SrcUse1, I_SrcUseV;
  logic [REG_WIDTH-1:0]  O_SrcData0, O_SrcData1;
  logic [VREG_WIDTH-1:0] O_SrcDataV;
  logic                  O_DepStall;

  typedef struct {
    string       tag;
    int          sel;   // 0: SrcData0, 1: SrcData1, 2: SrcDataV, 3: DepStall
    logic [63:0] val;
  } expItem_t;

  expItem_t expQ[$];
  int       totalCnt = 0;
  int       passCnt  = 0;

  logic [REG_WIDTH-1:0]  mS [16];
  logic [VREG_WIDTH-1:0] mV [16];

  always #5 I_CLOCK = ~I_CLOCK;

  wb_regfile #(.PEND_W(2)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
    .I_WriteBackEnable(I_WriteBackEnable), .I_WriteBackRegIdx(I_WriteBackRegIdx),
    .I_WriteBackData(I_WriteBackData), .I_WriteBackEnableV(I_WriteBackEnableV),
    .I_WriteBackRegIdxV(I_WriteBackRegIdxV), .I_WriteBackRegIdxV_Idx(I_WriteBackRegIdxV_Idx),
    .I_WriteBackDataV(I_WriteBackDataV), .I_WriteBackLaneMode(I_WriteBackLaneMode),
    .I_IssueValid(I_IssueValid), .I_IssueDestIdx(I_IssueDestIdx), .I_IssueIsVector(I_IssueIsVector),
    .I_SrcIdx0(I_SrcIdx0), .I_SrcIdx1(I_SrcIdx1), .I_SrcIdxV(I_SrcIdxV),
    .I_SrcUse0(I_SrcUse0), .I_SrcUse1(I_SrcUse1), .I_SrcUseV(I_SrcUseV),
    .O_SrcData0(O_SrcData0), .O_SrcData1(O_SrcData1), .O_SrcDataV(O_SrcDataV),
    .O_DepStall(O_DepStall)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expectOut(input string tag, input int sel, input logic [63:0] val);
    expItem_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    expQ.push_back(e);
  endtask

  // Compare queued expectations at the falling edge, then cross the next rising edge.
  task automatic step();
    @(negedge I_CLOCK);
    while (expQ.size() > 0) begin
      expItem_t e;
      e = expQ.pop_front();
      case (e.sel)
        0:       checkVal(e.tag, 64'(O_SrcData0), e.val);
        1:       checkVal(e.tag, 64'(O_SrcData1), e.val);
        2:       checkVal(e.tag, O_SrcDataV, e.val);
        default: checkVal(e.tag, 64'(O_DepStall), e.val);
      endcase
    end
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic idle();
    I_RESET_N = 1'b1; I_LOCK = 1'b1;
    I_WriteBackEnable = 1'b0; I_WriteBackRegIdx = '0; I_WriteBackData = '0;
    I_WriteBackEnableV = 1'b0; I_WriteBackRegIdxV = '0; I_WriteBackRegIdxV_Idx = '0;
    I_WriteBackDataV = '0; I_WriteBackLaneMode = 1'b0;
    I_IssueValid = 1'b0; I_IssueDestIdx = '0; I_IssueIsVector = 1'b0;
    I_SrcIdx0 = '0; I_SrcIdx1 = '0; I_SrcIdxV = '0;
    I_SrcUse0 = 1'b0; I_SrcUse1 = 1'b0; I_SrcUseV = 1'b0;
  endtask

  task automatic issueScalar(input logic [3:0] idx);
    I_IssueValid = 1'b1; I_IssueDestIdx = idx; I_IssueIsVector = 1'b0;
  endtask

  task automatic wbScalar(input logic [3:0] idx, input logic [REG_WIDTH-1:0] d);
    I_WriteBackEnable = 1'b1; I_WriteBackRegIdx = idx; I_WriteBackData = d;
  endtask

  task automatic useSrc0(input logic [3:0] idx);
    I_SrcIdx0 = idx; I_SrcUse0 = 1'b1;
  endtask

  initial begin
    logic [VREG_WIDTH-1:0] vNew, e2;
    logic                  vAct;
    logic [REG_WIDTH-1:0]  e0, e1;

    // Reset state
    idle(); I_RESET_N = 1'b0; step();
    idle(); I_SrcIdx0 = 4'd3; I_SrcIdx1 = 4'd5; I_SrcIdxV = 4'd2;
    expectOut("rst_s0", 0, 0); expectOut("rst_s1", 1, 0);
    expectOut("rst_v", 2, 0); expectOut("rst_stall", 3, 0);
    step();

    // Scalar write with same-cycle bypass, then registered read
    idle(); wbScalar(4'd3, 32'h1234); I_SrcIdx0 = 4'd3;
    expectOut("wr_r3_bypass", 0, 64'h1234); step();
    idle(); I_SrcIdx0 = 4'd3; I_SrcIdx1 = 4'd4;
    expectOut("rd_r3", 0, 64'h1234); expectOut("rd_r4", 1, 0); step();

    // RAW hazard on R5 released by its writeback
    idle(); issueScalar(4'd5); expectOut("iss_r5", 3, 0); step();
    idle(); useSrc0(4'd5); expectOut("raw_r5_a", 3, 1); step();
    idle(); useSrc0(4'd5); expectOut("raw_r5_b", 3, 1); step();
    idle(); useSrc0(4'd5); wbScalar(4'd5, 32'hBEEF);
    expectOut("raw_r5_wb_stall", 3, 0); expectOut("raw_r5_wb_data", 0, 64'hBEEF); step();
    idle(); useSrc0(4'd5); expectOut("raw_r5_done", 3, 0);
    expectOut("r5_data", 0, 64'hBEEF); step();

    // Vector full write, then single-lane write into lane 2
    idle(); I_WriteBackEnableV = 1'b1; I_WriteBackRegIdxV = 6'd2;
    I_WriteBackDataV = 64'h1111_2222_3333_4444; I_SrcIdxV = 4'd2;
    expectOut("v2_full_bypass", 2, 64'h1111_2222_3333_4444); step();
    idle(); I_WriteBackEnableV = 1'b1; I_WriteBackRegIdxV = 6'd2; I_WriteBackLaneMode = 1'b1;
    I_WriteBackRegIdxV_Idx = 2'd2; I_WriteBackData = 32'hFFFF_ABCD;
    I_WriteBackDataV = 64'hDEAD_DEAD_DEAD_DEAD; I_SrcIdxV = 4'd2;
    expectOut("v2_lane_bypass", 2, 64'h1111_ABCD_3333_4444); step();
    idle(); I_SrcIdxV = 4'd2; expectOut("v2_lane_rd", 2, 64'h1111_ABCD_3333_4444); step();

    // Counter saturation on R7
    for (int i = 0; i < 3; i++) begin
      idle(); issueScalar(4'd7); expectOut($sformatf("iss_r7_%0d", i), 3, 0); step();
    end
    idle(); issueScalar(4'd7); expectOut("iss_r7_full", 3, 1); step();
    idle(); issueScalar(4'd7); wbScalar(4'd7, 32'h77);
    expectOut("iss_r7_with_wb", 3, 0); step();
    idle(); issueScalar(4'd7); expectOut("iss_r7_still_full", 3, 1); step();
    idle(); wbScalar(4'd7, 32'h77); step();
    idle(); wbScalar(4'd7, 32'h77); step();
    idle(); useSrc0(4'd7); expectOut("r7_cnt1_stall", 3, 1); step();
    idle(); useSrc0(4'd7); wbScalar(4'd7, 32'h78); expectOut("r7_last_wb", 3, 0); step();
    idle(); useSrc0(4'd7); expectOut("r7_clear", 3, 0); step();

    // Lock low: no state change, no stall
    idle(); I_LOCK = 1'b0; issueScalar(4'd9); wbScalar(4'd9, 32'h99);
    expectOut("lock0_stall", 3, 0); step();
    idle(); useSrc0(4'd9); expectOut("lock0_no_wr", 0, 0);
    expectOut("lock0_no_issue", 3, 0); step();

    // Suppressed vector write to index 6'h22
    idle(); I_WriteBackEnableV = 1'b1; I_WriteBackRegIdxV = 6'h22;
    I_WriteBackDataV = '1; I_SrcIdxV = 4'd2;
    expectOut("v22_no_bypass", 2, 64'h1111_ABCD_3333_4444); step();
    idle(); I_SrcIdxV = 4'd2; expectOut("v22_unchanged", 2, 64'h1111_ABCD_3333_4444); step();

    // Reset mid-flight with R1 pending
    idle(); issueScalar(4'd1); step();
    idle(); useSrc0(4'd1); expectOut("r1_pending", 3, 1); step();
    idle(); I_RESET_N = 1'b0; issueScalar(4'd1); wbScalar(4'd3, 32'h5555); step();
    idle(); useSrc0(4'd1); I_SrcIdx1 = 4'd3; I_SrcIdxV = 4'd2;
    expectOut("rst2_stall", 3, 0); expectOut("rst2_r1", 0, 0);
    expectOut("rst2_r3", 1, 0); expectOut("rst2_v2", 2, 0); step();
    idle(); wbScalar(4'd1, 32'h4242); step();
    idle(); useSrc0(4'd1); expectOut("late_wb_data", 0, 64'h4242);
    expectOut("late_wb_stall", 3, 0); issueScalar(4'd1);
    step();
    idle(); useSrc0(4'd1); expectOut("r1_cnt_one", 3, 1); step();

    // Randomised reads and writes against a storage model
    idle(); I_RESET_N = 1'b0; step();
    for (int i = 0; i < 16; i++) begin mS[i] = '0; mV[i] = '0; end
    for (int c = 0; c < 60; c++) begin
      idle();
      I_WriteBackEnable      = 1'($urandom_range(0, 1));
      I_WriteBackRegIdx      = 4'($urandom);
      I_WriteBackData        = REG_WIDTH'($urandom);
      I_WriteBackEnableV     = 1'($urandom_range(0, 1));
      I_WriteBackRegIdxV     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {2'b00, 4'($urandom)};
      I_WriteBackRegIdxV_Idx = 2'($urandom);
      I_WriteBackDataV       = {32'($urandom), 32'($urandom)};
      I_WriteBackLaneMode    = 1'($urandom_range(0, 1));
      I_SrcIdx0 = 4'($urandom); I_SrcIdx1 = 4'($urandom); I_SrcIdxV = 4'($urandom);

      vNew = mV[I_WriteBackRegIdxV[3:0]];
      if (I_WriteBackLaneMode) begin
        case (I_WriteBackRegIdxV_Idx)
          2'd0: vNew[15:0]  = I_WriteBackData[15:0];
          2'd1: vNew[31:16] = I_WriteBackData[15:0];
          2'd2: vNew[47:32] = I_WriteBackData[15:0];
          default: vNew[63:48] = I_WriteBackData[15:0];
        endcase
      end else begin
        vNew = I_WriteBackDataV;
      end
      vAct = I_WriteBackEnableV && (I_WriteBackRegIdxV[5:4] == 2'b00);
      e0 = (I_WriteBackEnable && I_WriteBackRegIdx == I_SrcIdx0) ? I_WriteBackData : mS[I_SrcIdx0];
      e1 = (I_WriteBackEnable && I_WriteBackRegIdx == I_SrcIdx1) ? I_WriteBackData : mS[I_SrcIdx1];
      e2 = (vAct && I_WriteBackRegIdxV[3:0] == I_SrcIdxV) ? vNew : mV[I_SrcIdxV];
      expectOut($sformatf("rnd%0d_s0", c), 0, 64'(e0));
      expectOut($sformatf("rnd%0d_s1", c), 1, 64'(e1));
      expectOut($sformatf("rnd%0d_v", c), 2, e2);
      step();
      if (I_WriteBackEnable) mS[I_WriteBackRegIdx] = I_WriteBackData;
      if (vAct) mV[I_WriteBackRegIdxV[3:0]] = vNew;
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
